// File: rtl/cmp_minmax_ctrl_pkg.sv
// rtl/cmp_minmax_ctrl_pkg.sv - shared constants for the burst min/max controller
package cmp_minmax_ctrl_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FIRST = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  localparam int         DATA_W   = 4;
endpackage

// File: rtl/cmp_minmax_ctrl_if.sv
// rtl/cmp_minmax_ctrl_if.sv - sample handshake and result bus of the min/max controller
interface cmp_minmax_ctrl_if #(
  parameter int LEN_W = 4
);
  import cmp_minmax_ctrl_pkg::*;

  logic              start;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] max_val;
  logic [DATA_W-1:0] min_val;
  logic [LEN_W-1:0]  max_idx;
  logic [LEN_W-1:0]  min_idx;
  logic              all_eq;

  modport master (
    output start, len, in_valid, in_data,
    input  in_ready, busy, done, max_val, min_val, max_idx, min_idx, all_eq
  );

  modport slave (
    input  start, len, in_valid, in_data,
    output in_ready, busy, done, max_val, min_val, max_idx, min_idx, all_eq
  );
endinterface

// File: rtl/cmp_4_bit.sv
// rtl/cmp_4_bit.sv - shared 4-bit unsigned magnitude comparator, outputs forced low when disabled
module cmp_4_bit (
  input  logic       i_en,
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic       o_gt,
  output logic       o_eq,
  output logic       o_lt
);
  assign o_gt = i_en & (i_a >  i_b);
  assign o_eq = i_en & (i_a == i_b);
  assign o_lt = i_en & (i_a <  i_b);
endmodule

// File: rtl/cmp_minmax_ctrl.sv
// rtl/cmp_minmax_ctrl.sv - streams a sample burst through two comparators, reports max/min/index/all-equal
module cmp_minmax_ctrl
  import cmp_minmax_ctrl_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input logic               clk,
  input logic               rst_n,
  cmp_minmax_ctrl_if.slave  bus
);
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  w_cnt_inc;
  logic [DATA_W-1:0] r_max_val;
  logic [DATA_W-1:0] r_min_val;
  logic [LEN_W-1:0]  r_max_idx;
  logic [LEN_W-1:0]  r_min_idx;
  logic              r_all_eq;
  logic              w_ready;
  logic              w_xfer;
  logic              w_run;
  logic              w_max_gt;
  logic              w_max_eq;
  logic              w_max_lt;
  logic              w_min_gt;
  logic              w_min_eq;
  logic              w_min_lt;
  logic              w_unused_cmp;

  assign w_ready   = (r_state == ST_FIRST) || (r_state == ST_RUN);
  assign w_xfer    = w_ready && bus.in_valid;
  assign w_run     = (r_state == ST_RUN);
  assign w_cnt_inc = r_cnt + LEN_W'(1);

  cmp_4_bit U_MAX (
    .i_en (w_run),
    .i_a  (bus.in_data),
    .i_b  (r_max_val),
    .o_gt (w_max_gt),
    .o_eq (w_max_eq),
    .o_lt (w_max_lt)
  );

  cmp_4_bit U_MIN (
    .i_en (w_run),
    .i_a  (bus.in_data),
    .i_b  (r_min_val),
    .o_gt (w_min_gt),
    .o_eq (w_min_eq),
    .o_lt (w_min_lt)
  );

  assign w_unused_cmp = ^{w_max_lt, w_min_gt, w_min_eq};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_state_nxt = (bus.len == '0) ? ST_DONE : ST_FIRST;
      ST_FIRST: if (w_xfer)    w_state_nxt = (r_len == LEN_W'(1)) ? ST_DONE : ST_RUN;
      ST_RUN:   if (w_xfer && (w_cnt_inc == r_len)) w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Ties never update a result, so the earliest index of the extreme value is kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len     <= '0;
      r_cnt     <= '0;
      r_max_val <= '0;
      r_min_val <= '0;
      r_max_idx <= '0;
      r_min_idx <= '0;
      r_all_eq  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.start) begin
          r_len <= bus.len;
          r_cnt <= '0;
          if (bus.len == '0) begin
            r_max_val <= '0;
            r_min_val <= '0;
            r_max_idx <= '0;
            r_min_idx <= '0;
            r_all_eq  <= 1'b0;
          end
        end
        ST_FIRST: if (w_xfer) begin
          r_max_val <= bus.in_data;
          r_min_val <= bus.in_data;
          r_max_idx <= '0;
          r_min_idx <= '0;
          r_all_eq  <= 1'b1;
          r_cnt     <= LEN_W'(1);
        end
        ST_RUN: if (w_xfer) begin
          if (w_max_gt) begin
            r_max_val <= bus.in_data;
            r_max_idx <= r_cnt;
          end
          if (w_min_lt) begin
            r_min_val <= bus.in_data;
            r_min_idx <= r_cnt;
          end
          if (!w_max_eq) r_all_eq <= 1'b0;
          r_cnt <= w_cnt_inc;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.done     = (r_state == ST_DONE);
  assign bus.max_val  = r_max_val;
  assign bus.min_val  = r_min_val;
  assign bus.max_idx  = r_max_idx;
  assign bus.min_idx  = r_min_idx;
  assign bus.all_eq   = r_all_eq;
endmodule

// File: tb/tb_cmp_minmax_ctrl.sv
// tb/tb_cmp_minmax_ctrl.sv - randomized self-checking bench for cmp_minmax_ctrl
module tb_cmp_minmax_ctrl;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  logic [3:0] smp [16];

  cmp_minmax_ctrl_if #(.LEN_W(4)) bus ();

  cmp_minmax_ctrl #(.LEN_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " in_ready"}, bus.in_ready, 0);
    check({tag, " busy"},     bus.busy,     0);
    check({tag, " done"},     bus.done,     0);
    check({tag, " max_val"},  bus.max_val,  0);
    check({tag, " min_val"},  bus.min_val,  0);
    check({tag, " max_idx"},  bus.max_idx,  0);
    check({tag, " min_idx"},  bus.min_idx,  0);
    check({tag, " all_eq"},   bus.all_eq,   0);
  endtask

  // Drives one burst from smp[0..n-1]; start_at injects a stray start at that cycle count
  task automatic run_burst(input string name, input int n, input int gap, input bit rnd,
                           input int start_at, input bit start_on_done);
    int idx, lat, stalls, stall_left, exp_maxi, exp_mini;
    logic [3:0] exp_max, exp_min;
    bit exp_eq, done_seen, ready_seen, xfer;

    exp_max = 0; exp_min = 0; exp_maxi = 0; exp_mini = 0; exp_eq = 0;
    if (n > 0) begin
      exp_max = smp[0]; exp_min = smp[0]; exp_eq = 1;
      for (int i = 1; i < n; i++) begin
        if (smp[i] > exp_max) begin exp_max = smp[i]; exp_maxi = i; end
        if (smp[i] < exp_min) begin exp_min = smp[i]; exp_mini = i; end
        if (smp[i] != smp[0]) exp_eq = 0;
      end
    end

    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = 4'(n);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.len   = 4'($urandom_range(0, 15));
    lat = 2; idx = 0; stalls = 0; stall_left = 0;
    done_seen = 0; ready_seen = 0;
    while (!done_seen && lat < 300) begin
      if (bus.in_ready) ready_seen = 1;
      if (bus.done) done_seen = 1;
      else begin
        if (lat == start_at) begin bus.start = 1'b1; bus.len = 4'd9; end
        else bus.start = 1'b0;
        xfer = 0;
        if (idx < n && stall_left > 0) begin
          bus.in_valid = 1'b0; stall_left--; stalls++;
        end else if (idx < n) begin
          bus.in_valid = 1'b1; bus.in_data = smp[idx]; xfer = bus.in_ready;
        end else bus.in_valid = 1'b0;
        @(posedge clk); #1;
        lat++;
        if (xfer) begin
          idx++;
          stall_left = rnd ? int'($urandom_range(0, 2)) : gap;
        end
      end
    end
    bus.in_valid = 1'b0;
    check({name, " done_seen"}, done_seen, 1);
    check({name, " latency"},   lat,       n + 2 + stalls);
    check({name, " max_val"},   bus.max_val, exp_max);
    check({name, " min_val"},   bus.min_val, exp_min);
    check({name, " max_idx"},   bus.max_idx, exp_maxi);
    check({name, " min_idx"},   bus.min_idx, exp_mini);
    check({name, " all_eq"},    bus.all_eq,  exp_eq);
    check({name, " ready_seen"}, ready_seen, (n > 0) ? 1 : 0);
    if (start_on_done) begin
      bus.start = 1'b1;
      bus.len   = 4'd7;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({name, " done_pulse"}, bus.done, 0);
    check({name, " busy_after"}, bus.busy, 0);
    @(posedge clk); #1;
    check({name, " no_restart"}, bus.busy, 0);
    check({name, " max_hold"},   bus.max_val, exp_max);
    check({name, " min_hold"},   bus.min_val, exp_min);
  endtask

  initial begin
    int n, rng;
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // Reset in the middle of a burst
    @(negedge clk); bus.start = 1'b1; bus.len = 4'd5;
    @(posedge clk); #1; bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 4'hA;
    @(posedge clk); #1; bus.in_data = 4'h3;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    check("mid max_val", bus.max_val, 4'hA);
    rst_n = 1'b0; #2;
    check_zero("midreset");
    @(negedge clk); rst_n = 1'b1;
    smp[0] = 4'h7;
    run_burst("t1", 1, 0, 0, -1, 0);

    smp[0] = 3; smp[1] = 9; smp[2] = 1; smp[3] = 9;
    run_burst("t2", 4, 0, 0, -1, 0);

    smp[0] = 5; smp[1] = 5; smp[2] = 5;
    run_burst("t3", 3, 1, 0, -1, 0);

    run_burst("t4", 0, 0, 0, -1, 0);

    for (int i = 0; i < 15; i++) smp[i] = 4'(15 - i);
    run_burst("t5", 15, 0, 0, -1, 0);

    smp[0] = 6; smp[1] = 2;
    run_burst("t6", 2, 0, 0, 3, 1);

    for (int k = 0; k < 25; k++) begin
      n   = $urandom_range(0, 15);
      rng = (k % 3 == 0) ? 0 : ((k % 3 == 1) ? 3 : 15);
      for (int i = 0; i < 16; i++) smp[i] = 4'($urandom_range(0, rng));
      run_burst("rnd", n, 0, 1, -1, k[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
